// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline hazard/flow controller.
// Controller state encodings and default address width.
package pipe_ctrl_pkg;

    localparam int ADDR_W_DEF = 4;

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the EX load and the ID sources.
// R0 is hardwired zero, so it never creates a dependency.
module load_use_detect #(
    parameter int ADDR_W = 4
) (
    input  logic [ADDR_W-1:0] src0_addr_i,
    input  logic              src0_re_i,
    input  logic [ADDR_W-1:0] src1_addr_i,
    input  logic              src1_re_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic              dm_re_i,
    output logic              hazard_o
);

    logic dst_nz;
    logic hit0;
    logic hit1;

    // Dependency exists only on a real read of a non-zero load target
    always_comb begin
        dst_nz   = (dst_addr_i != '0);
        hit0     = src0_re_i && (src0_addr_i == dst_addr_i);
        hit1     = src1_re_i && (src1_addr_i == dst_addr_i);
        hazard_o = dm_re_i && dst_nz && (hit0 || hit1);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and flow controller for the 5-stage core.
// Sequences PC/IM_ID/ID_EX for load-use, branches, memory waits and HLT.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] src0_addr_ID,
    input  logic              src0_re_ID,
    input  logic [ADDR_W-1:0] src1_addr_ID,
    input  logic              src1_re_ID,
    input  logic [ADDR_W-1:0] dst_addr_ID_EX,
    input  logic              dm_re_ID_EX,
    input  logic              br_taken_ID_EX,
    input  logic              hlt_ID_EX,
    input  logic              dm_acc_EX_DM,
    input  logic              dm_rdy,
    output logic              stall,
    output logic              freeze,
    output logic              flow_change_ID_EX,
    output logic              flush_IM_ID,
    output logic              flush_ID_EX,
    output logic              hlt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [DCW-1:0]   drain_q;
    logic [DCW-1:0]   drain_d;
    logic             hlt_q;
    logic             hlt_d;
    logic [CNT_W-1:0] bubble_q;
    logic [CNT_W-1:0] bubble_d;

    logic load_use;
    logic mem_wait;
    logic stall_c;
    logic freeze_c;
    logic flow_c;
    logic fl_im_id_c;
    logic fl_id_ex_c;
    logic bubble_inc;

    load_use_detect #(
        .ADDR_W (ADDR_W)
    ) u_lud (
        .src0_addr_i (src0_addr_ID),
        .src0_re_i   (src0_re_ID),
        .src1_addr_i (src1_addr_ID),
        .src1_re_i   (src1_re_ID),
        .dst_addr_i  (dst_addr_ID_EX),
        .dm_re_i     (dm_re_ID_EX),
        .hazard_o    (load_use)
    );

    assign mem_wait = dm_acc_EX_DM && !dm_rdy;

    // Priority decode of control outputs and next state
    always_comb begin
        stall_c    = 1'b0;
        freeze_c   = 1'b0;
        flow_c     = 1'b0;
        fl_im_id_c = 1'b0;
        fl_id_ex_c = 1'b0;
        state_d    = state_q;
        drain_d    = drain_q;
        priority case (1'b1)
            (state_q == HALTED): begin
                stall_c    = 1'b1;
                fl_im_id_c = 1'b1;
            end
            mem_wait: begin
                stall_c  = 1'b1;
                freeze_c = 1'b1;
            end
            (state_q == DRAIN): begin
                stall_c    = 1'b1;
                fl_im_id_c = 1'b1;
                if (drain_q == '0) begin
                    state_d = HALTED;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            hlt_ID_EX: begin
                stall_c    = 1'b1;
                fl_im_id_c = 1'b1;
                fl_id_ex_c = 1'b1;
                state_d    = DRAIN;
                drain_d    = DRAIN_LOAD;
            end
            br_taken_ID_EX: begin
                flow_c     = 1'b1;
                fl_im_id_c = 1'b1;
                fl_id_ex_c = 1'b1;
            end
            load_use: begin
                stall_c    = 1'b1;
                fl_id_ex_c = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Halt flag and saturating lost-cycle counter next state
    always_comb begin
        hlt_d      = (state_d == HALTED);
        bubble_inc = (state_q != HALTED) && (stall_c || fl_id_ex_c);
        bubble_d   = bubble_q;
        if (bubble_inc && (bubble_q != '1)) begin
            bubble_d = bubble_q + 1'b1;
        end
    end

    // Controller state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            drain_q  <= '0;
            hlt_q    <= 1'b0;
            bubble_q <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            hlt_q    <= hlt_d;
            bubble_q <= bubble_d;
        end
    end

    // Outputs held low while reset is asserted
    always_comb begin
        stall             = rst_n && stall_c;
        freeze            = rst_n && freeze_c;
        flow_change_ID_EX = rst_n && flow_c;
        flush_IM_ID       = rst_n && fl_im_id_c;
        flush_ID_EX       = rst_n && fl_id_ex_c;
        hlt               = hlt_q;
        bubble_cnt        = bubble_q;
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random stimulus.
// Expected values come from a behavioural model of the control rules.
module tb_pipeline_hazard_ctrl;

    localparam int DRAIN = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] s0;
    logic       s0re;
    logic [3:0] s1;
    logic       s1re;
    logic [3:0] dst;
    logic       dm_re;
    logic       br;
    logic       hlt_in;
    logic       dm_acc;
    logic       dm_rdy;
    logic       stall;
    logic       freeze;
    logic       fc;
    logic       fim;
    logic       fie;
    logic       hlt;
    logic [15:0] bcnt;

    logic [5:0] obs;
    logic [5:0] exp_o;
    int tests = 0;
    int fails = 0;

    bit m_halted;
    bit m_draining;
    int m_left;
    int m_cnt;

    always #5 clk = ~clk;

    assign obs = {stall, freeze, fc, fim, fie, hlt};

    pipeline_hazard_ctrl #(
        .ADDR_W       (4),
        .DRAIN_CYCLES (DRAIN),
        .CNT_W        (16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .src0_addr_ID      (s0),
        .src0_re_ID        (s0re),
        .src1_addr_ID      (s1),
        .src1_re_ID        (s1re),
        .dst_addr_ID_EX    (dst),
        .dm_re_ID_EX       (dm_re),
        .br_taken_ID_EX    (br),
        .hlt_ID_EX         (hlt_in),
        .dm_acc_EX_DM      (dm_acc),
        .dm_rdy            (dm_rdy),
        .stall             (stall),
        .freeze            (freeze),
        .flow_change_ID_EX (fc),
        .flush_IM_ID       (fim),
        .flush_ID_EX       (fie),
        .hlt               (hlt),
        .bubble_cnt        (bcnt)
    );

    // Expected {stall,freeze,flow_change,flush_IM_ID,flush_ID_EX,hlt}
    function automatic logic [5:0] model_out();
        bit lu;
        lu = dm_re && (dst != 0) &&
             ((s0re && s0 == dst) || (s1re && s1 == dst));
        if (!rst_n) return 6'b000000;
        if (m_halted) return 6'b100101;
        if (dm_acc && !dm_rdy) return 6'b110000;
        if (m_draining) return 6'b100100;
        if (hlt_in) return 6'b100110;
        if (br) return 6'b001110;
        if (lu) return 6'b100010;
        return 6'b000000;
    endfunction

    task automatic model_reset();
        m_halted   = 0;
        m_draining = 0;
        m_left     = 0;
        m_cnt      = 0;
    endtask

    task automatic model_step();
        logic [5:0] o;
        if (!rst_n) begin
            model_reset();
        end else begin
            o = model_out();
            if (!m_halted && (o[5] || o[1]) && m_cnt < 65535) m_cnt++;
            if (!m_halted && !(dm_acc && !dm_rdy)) begin
                if (m_draining) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_halted   = 1;
                        m_draining = 0;
                    end
                end else if (hlt_in) begin
                    m_draining = 1;
                    m_left     = DRAIN;
                end
            end
        end
    endtask

    task automatic clear_in();
        s0 = 0; s0re = 0; s1 = 0; s1re = 0;
        dst = 0; dm_re = 0; br = 0; hlt_in = 0;
        dm_acc = 0; dm_rdy = 1;
    endtask

    task automatic apply();
        exp_o = model_out();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_in();
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_in();
        model_reset();
        br = 1; hlt_in = 1; dm_acc = 1; dm_rdy = 0;
        #1;
        tests++;
        if (obs !== 6'b000000) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 6'b000000);
        end
        tests++;
        if (bcnt !== 16'h0000) begin
            fails++;
            $display("FAIL reset_cnt: got %h expected 0000", bcnt);
        end
        do_reset();
    endtask

    task automatic test_load_use();
        dst = 3; dm_re = 1; s0 = 5; s0re = 1; s1 = 3; s1re = 1;
        apply();
        tests++;
        if (obs !== exp_o || obs !== 6'b100010) begin
            fails++;
            $display("FAIL lu_stall: got %b expected %b", obs, exp_o);
        end
        advance();
        dm_re = 0;
        apply();
        tests++;
        if (obs !== exp_o || obs !== 6'b000000) begin
            fails++;
            $display("FAIL lu_release: got %b expected %b", obs, exp_o);
        end
        advance();
        dst = 0; dm_re = 1; s0 = 0; s0re = 1; s1 = 0; s1re = 1;
        apply();
        tests++;
        if (obs !== exp_o) begin
            fails++;
            $display("FAIL lu_r0: got %b expected %b", obs, exp_o);
        end
        advance();
        dst = 3; s0 = 3; s0re = 0; s1 = 3; s1re = 0;
        apply();
        tests++;
        if (obs !== exp_o) begin
            fails++;
            $display("FAIL lu_no_read: got %b expected %b", obs, exp_o);
        end
        advance();
        tests++;
        if (bcnt !== 16'(m_cnt) || m_cnt != 1) begin
            fails++;
            $display("FAIL lu_cnt: got %0d expected %0d", bcnt, m_cnt);
        end
        clear_in();
    endtask

    task automatic test_branch();
        dst = 7; dm_re = 1; s0 = 7; s0re = 1; br = 1;
        apply();
        tests++;
        if (obs !== exp_o || obs !== 6'b001110) begin
            fails++;
            $display("FAIL br_over_lu: got %b expected %b", obs, exp_o);
        end
        advance();
        clear_in();
    endtask

    task automatic test_mem_wait();
        int base;
        base = m_cnt;
        br = 1; dm_acc = 1; dm_rdy = 0;
        for (int i = 0; i < 4; i++) begin
            apply();
            tests++;
            if (obs !== exp_o || obs !== 6'b110000) begin
                fails++;
                $display("FAIL wait_%0d: got %b expected %b", i, obs, exp_o);
            end
            advance();
        end
        tests++;
        if (bcnt !== 16'(base + 4)) begin
            fails++;
            $display("FAIL wait_cnt: got %0d expected %0d", bcnt, base + 4);
        end
        dm_rdy = 1;
        apply();
        tests++;
        if (obs !== exp_o || obs !== 6'b001110) begin
            fails++;
            $display("FAIL wait_release: got %b expected %b", obs, exp_o);
        end
        advance();
        tests++;
        if (bcnt !== 16'(base + 5)) begin
            fails++;
            $display("FAIL wait_cnt2: got %0d expected %0d", bcnt, base + 5);
        end
        clear_in();
    endtask

    task automatic test_halt();
        hlt_in = 1; br = 1;
        apply();
        tests++;
        if (obs !== exp_o || obs !== 6'b100110) begin
            fails++;
            $display("FAIL hlt_enter: got %b expected %b", obs, exp_o);
        end
        advance();
        clear_in();
        for (int i = 1; i <= DRAIN; i++) begin
            apply();
            tests++;
            if (obs !== exp_o || hlt !== 1'b0) begin
                fails++;
                $display("FAIL drain_%0d: got %b expected %b", i, obs, exp_o);
            end
            advance();
        end
        apply();
        tests++;
        if (obs !== exp_o || obs !== 6'b100101) begin
            fails++;
            $display("FAIL halted: got %b expected %b", obs, exp_o);
        end
        do_reset();
        hlt_in = 1;
        apply();
        advance();
        hlt_in = 0;
        rst_n = 0;
        model_reset();
        #1;
        tests++;
        if (hlt !== 1'b0 || stall !== 1'b0) begin
            fails++;
            $display("FAIL drain_reset: got hlt=%b stall=%b expected 0 0", hlt, stall);
        end
        @(posedge clk);
        #1 rst_n = 1;
        apply();
        tests++;
        if (obs !== exp_o || obs !== 6'b000000) begin
            fails++;
            $display("FAIL post_reset: got %b expected %b", obs, exp_o);
        end
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (m_halted && $urandom_range(0, 3) == 0) do_reset();
            s0     = 4'($urandom_range(0, 3));
            s1     = 4'($urandom_range(0, 3));
            dst    = 4'($urandom_range(0, 3));
            s0re   = 1'($urandom);
            s1re   = 1'($urandom);
            dm_re  = 1'($urandom);
            br     = ($urandom_range(0, 3) == 0);
            hlt_in = ($urandom_range(0, 30) == 0);
            dm_acc = 1'($urandom);
            dm_rdy = ($urandom_range(0, 2) != 0);
            apply();
            tests++;
            if (obs !== exp_o) begin
                fails++;
                $display("FAIL rand_out[%0d]: got %b expected %b", n, obs, exp_o);
            end
            tests++;
            if (bcnt !== 16'(m_cnt)) begin
                fails++;
                $display("FAIL rand_cnt[%0d]: got %0d expected %0d", n, bcnt, m_cnt);
            end
            advance();
        end
        clear_in();
    endtask

    task automatic test_saturation();
        do_reset();
        dm_acc = 1; dm_rdy = 0;
        for (int i = 0; i < 65534; i++) advance();
        tests++;
        if (bcnt !== 16'hFFFE || m_cnt != 65534) begin
            fails++;
            $display("FAIL sat_pre: got %h expected fffe", bcnt);
        end
        for (int i = 0; i < 3; i++) advance();
        tests++;
        if (bcnt !== 16'hFFFF || bcnt !== 16'(m_cnt)) begin
            fails++;
            $display("FAIL sat_hold: got %h expected ffff", bcnt);
        end
        clear_in();
    endtask

    initial begin
        clear_in();
        rst_n = 0;
        model_reset();
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_halt();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
